instr_encoder: RTL and testbench

// - Inverse of the CPU's main decoder: takes one encode request (kind + fields) and emits
//   ARM machine words plus an instruction-memory write address, for boot/program loaders and benches.
// - Covers DP reg/imm, LDR/STR (all index modes), B/BL, MUL/MULL, BX, and LDC. LDC is a pseudo-op

---
 rtl/arm_isa_pkg.sv | 56 +++++
 rtl/instr_pack.sv | 42 ++++
 rtl/instr_encoder.sv | 144 ++++++++++++++
 tb/tb_instr_encoder.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_isa_pkg.sv
// Shared ARM encoding vocabulary: request kinds, condition/opcode constants and
// the request-field bundle used by the encoder and its word packer.
package arm_isa_pkg;

    typedef enum logic [3:0] {
        KIND_DP_REG = 4'd0,
        KIND_DP_IMM = 4'd1,
        KIND_MEM    = 4'd2,
        KIND_B      = 4'd3,
        KIND_BL     = 4'd4,
        KIND_MUL    = 4'd5,
        KIND_MULL   = 4'd6,
        KIND_BX     = 4'd7,
        KIND_LDC    = 4'd8
    } kind_t;

    localparam logic [3:0]  COND_AL = 4'hE;
    localparam logic [3:0]  CMD_MOV = 4'hD;
    localparam logic [3:0]  CMD_ORR = 4'hC;
    localparam logic [3:0]  CMD_ADD = 4'h4;

    // Fixed bit patterns that sit in bits [27:4] (BX) and [7:4] (multiplies).
    localparam logic [23:0] BX_TAG  = 24'h12FFF1;
    localparam logic [3:0]  MUL_TAG = 4'b1001;

    localparam logic [3:0]  LDC_ROT_B1 = 4'd12;
    localparam logic [3:0]  LDC_ROT_B2 = 4'd8;
    localparam logic [3:0]  LDC_ROT_B3 = 4'd4;

    typedef struct packed {
        kind_t       kind;
        logic [3:0]  cond;
        logic [3:0]  cmd;
        logic [5:0]  flags;
        logic [3:0]  rd;
        logic [3:0]  rn;
        logic [3:0]  rm;
        logic [3:0]  ra;
        logic [31:0] imm;
    } req_fields_t;

    function automatic logic kind_legal(input logic [3:0] k);
        return k <= 4'(KIND_LDC);
    endfunction

    // Rotation field that places byte N of the constant back into its lane.
    function automatic logic [3:0] ldc_rot(input logic [1:0] step);
        case (step)
            2'd1:    return LDC_ROT_B1;
            2'd2:    return LDC_ROT_B2;
            2'd3:    return LDC_ROT_B3;
            default: return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: registered request fields plus LDC step -> one ARM word.
module instr_pack
    import arm_isa_pkg::*;
(
    input  req_fields_t f,
    input  logic [1:0]  ldc_step,
    output logic [31:0] word
);

    logic [27:0] body;
    logic [7:0]  ldc_byte;

    always_comb begin
        ldc_byte = f.imm[{ldc_step, 3'b000} +: 8];
        body     = '0;
        case (f.kind)
            KIND_DP_REG, KIND_DP_IMM:
                body = {2'b00, f.kind == KIND_DP_IMM, f.cmd, f.flags[0], f.rn, f.rd, f.imm[11:0]};
            KIND_MEM:
                body = {2'b01, f.flags, f.rn, f.rd, f.imm[11:0]};
            KIND_B, KIND_BL:
                body = {3'b101, f.kind == KIND_BL, f.imm[23:0]};
            KIND_MUL:
                body = {6'b000000, f.flags[1:0], f.rd, f.ra, f.rm, MUL_TAG, f.rn};
            KIND_MULL:
                body = {5'b00001, f.flags[2:0], f.rd, f.ra, f.rm, MUL_TAG, f.rn};
            KIND_BX:
                body = {BX_TAG, f.rm};
            KIND_LDC: begin
                // Step 0 seeds the register with MOV; later steps OR in one byte each.
                if (ldc_step == 2'd0)
                    body = {3'b001, CMD_MOV, 1'b0, 4'h0, f.rd, 4'h0, ldc_byte};
                else
                    body = {3'b001, CMD_ORR, 1'b0, f.rd, f.rd, ldc_rot(ldc_step), ldc_byte};
            end
            default: body = '0;
        endcase
    end

    assign word = {f.cond, body};

endmodule

// File: rtl/instr_encoder.sv
// Encode-request to instruction-memory write stream: IDLE/EMIT handshake FSM,
// request capture, LDC byte sequencing and the word-address counter.
module instr_encoder
    import arm_isa_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_kind,
    input  logic [3:0]        req_cond,
    input  logic [3:0]        req_cmd,
    input  logic [5:0]        req_flags,
    input  logic [3:0]        req_rd,
    input  logic [3:0]        req_rn,
    input  logic [3:0]        req_rm,
    input  logic [3:0]        req_ra,
    input  logic [31:0]       req_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              err,
    input  logic              addr_clr
);

    typedef enum logic {ST_IDLE, ST_EMIT} state_t;

    state_t             state_q, state_d;
    req_fields_t        fields_q, fields_d;
    logic [2:0]         pend_q, pend_d;
    logic [1:0]         step_q, step_d;
    logic               out_valid_q, out_valid_d;
    logic               err_q, err_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;

    logic               xfer;
    logic               is_last;
    logic [ADDR_W-1:0]  base;

    assign base    = ADDR_W'(BASE_ADDR);
    assign xfer    = out_valid_q && out_ready;
    // pend_q holds the bytes still to be ORed in after the current word.
    assign is_last = (fields_q.kind != KIND_LDC) || (pend_q == 3'b000);

    always_comb begin
        state_d     = state_q;
        fields_d    = fields_q;
        pend_d      = pend_q;
        step_d      = step_q;
        out_valid_d = out_valid_q;
        err_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (kind_legal(req_kind)) begin
                        state_d        = ST_EMIT;
                        out_valid_d    = 1'b1;
                        fields_d.kind  = kind_t'(req_kind);
                        fields_d.cond  = req_cond;
                        fields_d.cmd   = req_cmd;
                        fields_d.flags = req_flags;
                        fields_d.rd    = req_rd;
                        fields_d.rn    = req_rn;
                        fields_d.rm    = req_rm;
                        fields_d.ra    = req_ra;
                        fields_d.imm   = req_imm;
                        pend_d         = {req_imm[31:24] != 8'h00,
                                          req_imm[23:16] != 8'h00,
                                          req_imm[15:8]  != 8'h00};
                        step_d         = 2'd0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_EMIT: begin
                if (xfer) begin
                    out_valid_d = 1'b0;
                    if (is_last) begin
                        state_d = ST_IDLE;
                    end else if (pend_q[0]) begin
                        step_d    = 2'd1;
                        pend_d[0] = 1'b0;
                    end else if (pend_q[1]) begin
                        step_d    = 2'd2;
                        pend_d[1] = 1'b0;
                    end else begin
                        step_d    = 2'd3;
                        pend_d[2] = 1'b0;
                    end
                end else if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (addr_clr)
            addr_d = base;
        else if (xfer)
            addr_d = addr_q + ADDR_W'(1);
        else
            addr_d = addr_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            fields_q    <= '0;
            pend_q      <= 3'b000;
            step_q      <= 2'd0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= base;
        end else begin
            state_q     <= state_d;
            fields_q    <= fields_d;
            pend_q      <= pend_d;
            step_q      <= step_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            addr_q      <= addr_d;
        end
    end

    instr_pack u_pack (
        .f        (fields_q),
        .ldc_step (step_q),
        .word     (out_instr)
    );

    assign req_ready = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_last  = out_valid_q && is_last;
    assign out_addr  = addr_q;
    assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: two instances (8-bit address with non-zero base,
// and a 2-bit wrapping address) share one request stream and are compared each cycle.
module tb_instr_encoder;
    import arm_isa_pkg::*;

    localparam logic [7:0] BASE_A = 8'd16;
    localparam logic [1:0] BASE_B = 2'd0;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, out_ready, addr_clr;
    logic [3:0]  req_kind, req_cond, req_cmd, req_rd, req_rn, req_rm, req_ra;
    logic [5:0]  req_flags;
    logic [31:0] req_imm;

    logic        req_ready_a, out_valid_a, out_last_a, err_a;
    logic [31:0] out_instr_a;
    logic [7:0]  out_addr_a;
    logic        req_ready_b, out_valid_b, out_last_b, err_b;
    logic [31:0] out_instr_b;
    logic [1:0]  out_addr_b;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(8), .BASE_ADDR(16)) dut_a (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_a),
        .req_kind(req_kind), .req_cond(req_cond), .req_cmd(req_cmd), .req_flags(req_flags),
        .req_rd(req_rd), .req_rn(req_rn), .req_rm(req_rm), .req_ra(req_ra), .req_imm(req_imm),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_instr(out_instr_a),
        .out_addr(out_addr_a), .out_last(out_last_a), .err(err_a), .addr_clr(addr_clr)
    );

    instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut_b (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_b),
        .req_kind(req_kind), .req_cond(req_cond), .req_cmd(req_cmd), .req_flags(req_flags),
        .req_rd(req_rd), .req_rn(req_rn), .req_rm(req_rm), .req_ra(req_ra), .req_imm(req_imm),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_instr(out_instr_b),
        .out_addr(out_addr_b), .out_last(out_last_b), .err(err_b), .addr_clr(addr_clr)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic        last;
    } word_t;

    int          checks = 0;
    int          errors = 0;
    word_t       exp_q[$];
    logic [31:0] got_instr[$];
    logic        got_last[$];
    logic [7:0]  got_addr_a[$];
    logic [1:0]  got_addr_b[$];
    logic [7:0]  ma;
    logic [1:0]  mb;
    logic        last_xfer, exp_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] f(input logic [31:0] v, input int p);
        return v << p;
    endfunction

    // Expected word list for one request, built directly from the ARM field layouts.
    task automatic model_push(input logic [3:0] k, input logic [3:0] cond, input logic [3:0] cmd,
                              input logic [5:0] fl, input logic [3:0] rd, input logic [3:0] rn,
                              input logic [3:0] rm, input logic [3:0] ra, input logic [31:0] imm);
        logic [31:0] c;
        logic [7:0]  b[4];
        int          nz[$];
        c = f(cond, 28);
        for (int i = 0; i < 4; i++) b[i] = imm[8*i +: 8];
        case (k)
            4'd0, 4'd1: exp_q.push_back('{c | f(k == 4'd1, 25) | f(cmd, 21) | f(fl[0], 20) |
                                          f(rn, 16) | f(rd, 12) | imm[11:0], 1'b1});
            4'd2: exp_q.push_back('{c | f(1, 26) | f(fl, 20) | f(rn, 16) | f(rd, 12) | imm[11:0], 1'b1});
            4'd3, 4'd4: exp_q.push_back('{c | f(5, 25) | f(k == 4'd4, 24) | imm[23:0], 1'b1});
            4'd5: exp_q.push_back('{c | f(fl[1], 21) | f(fl[0], 20) | f(rd, 16) | f(ra, 12) |
                                    f(rm, 8) | f(9, 4) | rn, 1'b1});
            4'd6: exp_q.push_back('{c | f(1, 23) | f(fl[2], 22) | f(fl[1], 21) | f(fl[0], 20) |
                                    f(rd, 16) | f(ra, 12) | f(rm, 8) | f(9, 4) | rn, 1'b1});
            4'd7: exp_q.push_back('{c | 32'h012FFF10 | rm, 1'b1});
            4'd8: begin
                for (int i = 1; i < 4; i++) if (b[i] != 8'h00) nz.push_back(i);
                exp_q.push_back('{c | f(1, 25) | f(4'hD, 21) | f(rd, 12) | b[0], nz.size() == 0});
                for (int j = 0; j < nz.size(); j++)
                    exp_q.push_back('{c | f(1, 25) | f(4'hC, 21) | f(rd, 16) | f(rd, 12) |
                                      f(16 - 4 * nz[j], 8) | b[nz[j]], j == nz.size() - 1});
            end
            default: ;
        endcase
    endtask

    task automatic model_reset();
        exp_q.delete();
        ma        = BASE_A;
        mb        = BASE_B;
        last_xfer = 1'b0;
        exp_err   = 1'b0;
    endtask

    // One clock: resolve the handshake seen before the edge, then compare at the falling edge.
    task automatic tick();
        logic xfer, acc, clr, bad;
        logic exp_v;
        xfer = out_valid_a && out_ready;
        acc  = req_valid && req_ready_a;
        clr  = addr_clr;
        bad  = acc && (req_kind > 4'd8);
        if (xfer) begin
            got_instr.push_back(out_instr_a);
            got_last.push_back(out_last_a);
            got_addr_a.push_back(out_addr_a);
            got_addr_b.push_back(out_addr_b);
        end
        @(posedge clk);
        if (xfer && exp_q.size() != 0) void'(exp_q.pop_front());
        if (acc && !bad) model_push(req_kind, req_cond, req_cmd, req_flags, req_rd, req_rn, req_rm, req_ra, req_imm);
        if (clr) begin
            ma = BASE_A;
            mb = BASE_B;
        end else if (xfer) begin
            ma = ma + 8'd1;
            mb = mb + 2'd1;
        end
        last_xfer = xfer;
        exp_err   = bad;
        @(negedge clk);
        exp_v = (exp_q.size() != 0) && !last_xfer;
        chk("valid_a", out_valid_a, exp_v);
        chk("valid_b", out_valid_b, exp_v);
        chk("req_ready_a", req_ready_a, exp_q.size() == 0);
        chk("req_ready_b", req_ready_b, exp_q.size() == 0);
        chk("err_a", err_a, exp_err);
        chk("err_b", err_b, exp_err);
        chk("ready_valid_excl", req_ready_a && out_valid_a, 1'b0);
        if (exp_v) begin
            chk("instr_a", out_instr_a, exp_q[0].instr);
            chk("instr_b", out_instr_b, exp_q[0].instr);
            chk("last_a", out_last_a, exp_q[0].last);
            chk("last_b", out_last_b, exp_q[0].last);
            chk("addr_a", out_addr_a, ma);
            chk("addr_b", out_addr_b, mb);
        end
    endtask

    task automatic send(input logic [3:0] k, input logic [3:0] cond, input logic [3:0] cmd,
                        input logic [5:0] fl, input logic [3:0] rd, input logic [3:0] rn,
                        input logic [3:0] rm, input logic [3:0] ra, input logic [31:0] imm);
        logic a;
        int   n;
        req_kind = k; req_cond = cond; req_cmd = cmd; req_flags = fl;
        req_rd = rd; req_rn = rn; req_rm = rm; req_ra = ra; req_imm = imm;
        req_valid = 1'b1;
        n = 0;
        do begin
            a = req_valid && req_ready_a;
            tick();
            n++;
        end while (!a && n < 50);
        req_valid = 1'b0;
        chk("accept", a, 1'b1);
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic check_reset_vals();
        chk("rst_req_ready", req_ready_a, 1'b1);
        chk("rst_out_valid", out_valid_a, 1'b0);
        chk("rst_out_last", out_last_a, 1'b0);
        chk("rst_err", err_a, 1'b0);
        chk("rst_out_instr", out_instr_a, 32'h0);
        chk("rst_out_addr_a", out_addr_a, 8'd16);
        chk("rst_out_addr_b", out_addr_b, 2'd0);
        chk("rst_out_valid_b", out_valid_b, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int g;
        reset = 1'b1; req_valid = 1'b0; out_ready = 1'b1; addr_clr = 1'b0;
        req_kind = '0; req_cond = '0; req_cmd = '0; req_flags = '0;
        req_rd = '0; req_rn = '0; req_rm = '0; req_ra = '0; req_imm = '0;
        repeat (2) @(negedge clk);
        check_reset_vals();
        model_reset();
        reset = 1'b0;
        tick();

        // DP_IMM ADD r1, r2, #5
        g = got_instr.size();
        send(KIND_DP_IMM, COND_AL, CMD_ADD, 6'd0, 4'd1, 4'd2, 4'd0, 4'd0, 32'd5);
        drain();
        chk("dp_imm_word", got_instr[g], 32'hE2821005);
        chk("dp_imm_last", got_last[g], 1'b1);
        chk("dp_imm_addr", got_addr_a[g], 8'd16);

        // LDR held off by the sink for three cycles
        out_ready = 1'b0;
        g = got_instr.size();
        send(KIND_MEM, COND_AL, 4'd0, 6'b011001, 4'd3, 4'd4, 4'd0, 4'd0, 32'd8);
        repeat (3) tick();
        chk("hold_valid", out_valid_a, 1'b1);
        chk("hold_word", out_instr_a, 32'hE5943008);
        chk("hold_addr", out_addr_a, 8'd17);
        chk("hold_req_ready", req_ready_a, 1'b0);
        drain();
        chk("mem_word", got_instr[g], 32'hE5943008);

        g = got_instr.size();
        send(KIND_BL, COND_AL, 4'd0, 6'd0, 4'd0, 4'd0, 4'd0, 4'd0, 32'h10);
        drain();
        send(KIND_BX, COND_AL, 4'd0, 6'd0, 4'd0, 4'd0, 4'd14, 4'd0, 32'd0);
        drain();
        send(KIND_MUL, COND_AL, 4'd0, 6'd0, 4'd1, 4'd2, 4'd3, 4'd0, 32'd0);
        drain();
        chk("bl_word", got_instr[g], 32'hEB000010);
        chk("bx_word", got_instr[g+1], 32'hE12FFF1E);
        chk("mul_word", got_instr[g+2], 32'hE0010392);

        // LDC r0, #0x12003400 and LDC r0, #0
        g = got_instr.size();
        send(KIND_LDC, COND_AL, 4'd0, 6'd0, 4'd0, 4'd0, 4'd0, 4'd0, 32'h12003400);
        drain();
        send(KIND_LDC, COND_AL, 4'd0, 6'd0, 4'd0, 4'd0, 4'd0, 4'd0, 32'h0);
        drain();
        chk("ldc_w0", got_instr[g], 32'hE3A00000);
        chk("ldc_w1", got_instr[g+1], 32'hE3800C34);
        chk("ldc_w2", got_instr[g+2], 32'hE3800412);
        chk("ldc_last0", got_last[g], 1'b0);
        chk("ldc_last1", got_last[g+1], 1'b0);
        chk("ldc_last2", got_last[g+2], 1'b1);
        chk("ldc_addr0", got_addr_a[g], 8'd21);
        chk("ldc_addr1", got_addr_a[g+1], 8'd22);
        chk("ldc_addr2", got_addr_a[g+2], 8'd23);
        chk("ldc0_word", got_instr[g+3], 32'hE3A00000);
        chk("ldc0_last", got_last[g+3], 1'b1);

        // Model-only kinds: MULL, DP_REG with S, STR, B with a non-AL condition, 4-word LDC
        send(KIND_MULL, COND_AL, 4'd0, 6'b000111, 4'd9, 4'd5, 4'd6, 4'd8, 32'd0);
        drain();
        send(KIND_DP_REG, 4'h0, CMD_ORR, 6'd1, 4'd7, 4'd3, 4'd0, 4'd0, 32'h00000F02);
        drain();
        send(KIND_MEM, 4'h1, 4'd0, 6'b011000, 4'd2, 4'd13, 4'd0, 4'd0, 32'h00000ABC);
        drain();
        send(KIND_B, 4'hA, 4'd0, 6'd0, 4'd0, 4'd0, 4'd0, 4'd0, 32'hFFFFFFFE);
        drain();
        send(KIND_LDC, COND_AL, 4'd0, 6'd0, 4'd5, 4'd0, 4'd0, 4'd0, 32'hDEADBEEF);
        drain();

        // Re-base, then five words on the 2-bit counter wrap 0,1,2,3,0
        addr_clr = 1'b1;
        tick();
        addr_clr = 1'b0;
        g = got_instr.size();
        for (int i = 0; i < 5; i++) begin
            send(KIND_DP_IMM, COND_AL, CMD_ADD, 6'd0, 4'(i), 4'd1, 4'd0, 4'd0, 32'(i));
            drain();
        end
        chk("wrap_addr0", got_addr_b[g], 2'd0);
        chk("wrap_addr1", got_addr_b[g+1], 2'd1);
        chk("wrap_addr2", got_addr_b[g+2], 2'd2);
        chk("wrap_addr3", got_addr_b[g+3], 2'd3);
        chk("wrap_addr4", got_addr_b[g+4], 2'd0);
        chk("wide_addr4", got_addr_a[g+4], 8'd20);

        // addr_clr coincident with a transfer: following word lands at the base
        out_ready = 1'b0;
        send(KIND_B, COND_AL, 4'd0, 6'd0, 4'd0, 4'd0, 4'd0, 4'd0, 32'h000123);
        addr_clr  = 1'b1;
        out_ready = 1'b1;
        tick();
        addr_clr = 1'b0;
        g = got_instr.size();
        send(KIND_BX, COND_AL, 4'd0, 6'd0, 4'd0, 4'd0, 4'd3, 4'd0, 32'd0);
        drain();
        chk("clr_xfer_addr_a", got_addr_a[g], 8'd16);
        chk("clr_xfer_addr_b", got_addr_b[g], 2'd0);

        // Illegal kind: single-cycle err, nothing emitted
        send(4'hF, COND_AL, 4'd0, 6'd0, 4'd0, 4'd0, 4'd0, 4'd0, 32'd0);
        chk("illegal_err", err_a, 1'b1);
        chk("illegal_no_valid", out_valid_a, 1'b0);
        tick();
        chk("illegal_err_drop", err_a, 1'b0);
        chk("illegal_still_idle", req_ready_a, 1'b1);

        // Reset asserted while the second LDC word is presented
        out_ready = 1'b0;
        send(KIND_LDC, COND_AL, 4'd0, 6'd0, 4'd0, 4'd0, 4'd0, 4'd0, 32'h12003400);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        chk("mid_ldc_word2", out_instr_a, 32'hE3800C34);
        reset = 1'b1;
        #1;
        check_reset_vals();
        model_reset();
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        g = got_instr.size();
        send(KIND_DP_IMM, COND_AL, CMD_ADD, 6'd0, 4'd1, 4'd2, 4'd0, 4'd0, 32'd5);
        drain();
        chk("post_reset_word", got_instr[g], 32'hE2821005);
        chk("post_reset_addr", got_addr_a[g], 8'd16);
        chk("post_reset_last", got_last[g], 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
